// File: rtl/return_addr_stack_pkg.sv
// Shared constants and op decode for the return-address stack.
// Provides `WORD_LEN (default 32) and the `RAS_OCC_W(depth) occupancy-width macro.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif
`ifndef RAS_OCC_W
`define RAS_OCC_W(depth) ($clog2(depth) + 1)
`endif

package return_addr_stack_pkg;

  localparam int unsigned RAS_DEPTH    = 8;
  localparam int unsigned RAS_PTR_W    = $clog2(RAS_DEPTH);
  localparam int unsigned RAS_WORD_LEN = `WORD_LEN;

  // Encoding is {push, pop} so the decode is a plain cast.
  typedef enum logic [1:0] {
    RAS_OP_NONE = 2'b00,
    RAS_OP_POP  = 2'b01,
    RAS_OP_PUSH = 2'b10,
    RAS_OP_SWAP = 2'b11
  } ras_op_e;

  function automatic ras_op_e ras_decode(input logic push, input logic pop);
    return ras_op_e'({push, pop});
  endfunction

endpackage

// File: rtl/ras_entry_file.sv
// Return-address storage: DEPTH x AW registers, one write port, one async read port.
module ras_entry_file #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 32
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [AW-1:0]            i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [AW-1:0]            o_rdata
);

  logic [AW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/return_addr_stack.sv
// Circular return-address predictor with overwrite-on-overflow and registered mispredict.
// Optional RAS_STATS_EN adds saturating hit_count / miss_count outputs.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif
`ifndef RAS_OCC_W
`define RAS_OCC_W(depth) ($clog2(depth) + 1)
`endif

module return_addr_stack
  import return_addr_stack_pkg::*;
#(
  parameter int unsigned DEPTH = RAS_DEPTH,
  parameter int unsigned AW    = `WORD_LEN
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         flush,
  input  logic                         push,
  input  logic [AW-1:0]                push_addr,
  input  logic                         pop,
  input  logic [AW-1:0]                jr_target,
  output logic [AW-1:0]                pred_addr,
  output logic                         pred_valid,
  output logic                         mispredict,
  output logic [AW-1:0]                mispredict_target,
  output logic [`RAS_OCC_W(DEPTH)-1:0] occupancy
`ifdef RAS_STATS_EN
  ,
  output logic [15:0]                  hit_count,
  output logic [15:0]                  miss_count
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned OW = `RAS_OCC_W(DEPTH);
  localparam logic [OW-1:0] FULL_OCC = OW'(DEPTH);

  logic [PW-1:0] r_ptr;
  logic [OW-1:0] r_occ;
  logic          r_mispredict;
  logic [AW-1:0] r_mtarget;

  ras_op_e       w_op;
  logic          w_adv;
  logic          w_empty;
  logic          w_full;
  logic          w_miss;
  logic [AW-1:0] w_top;
  logic [PW-1:0] w_nxt_ptr;
  logic [OW-1:0] w_nxt_occ;
  logic          w_we;
  logic [PW-1:0] w_waddr;

  ras_entry_file #(.DEPTH(DEPTH), .AW(AW)) u_entries (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (push_addr),
    .i_raddr (r_ptr),
    .o_rdata (w_top)
  );

  always_comb begin
    w_op      = ras_decode(push, pop);
    w_adv     = !flush && !stall;
    w_empty   = (r_occ == '0);
    w_full    = (r_occ == FULL_OCC);
    w_miss    = w_empty || (w_top != jr_target);
    w_nxt_ptr = r_ptr;
    w_nxt_occ = r_occ;
    w_we      = 1'b0;
    w_waddr   = r_ptr;
    if (w_adv) begin
      unique case (w_op)
        RAS_OP_PUSH: begin
          w_nxt_ptr = r_ptr + PW'(1);
          w_waddr   = r_ptr + PW'(1);
          w_we      = 1'b1;
          if (!w_full) w_nxt_occ = r_occ + OW'(1);
        end
        RAS_OP_POP: begin
          if (!w_empty) begin
            w_nxt_ptr = r_ptr - PW'(1);
            w_nxt_occ = r_occ - OW'(1);
          end
        end
        // JR replaced by JAL: the check above sees the old top, then it is overwritten in place.
        RAS_OP_SWAP: begin
          w_we = 1'b1;
          if (w_empty) w_nxt_occ = OW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr        <= '0;
      r_occ        <= '0;
      r_mispredict <= 1'b0;
      r_mtarget    <= '0;
    end else if (flush) begin
      r_ptr        <= '0;
      r_occ        <= '0;
      r_mispredict <= 1'b0;
    end else if (!stall) begin
      r_ptr        <= w_nxt_ptr;
      r_occ        <= w_nxt_occ;
      r_mispredict <= pop && w_miss;
      if (pop && w_miss) r_mtarget <= jr_target;
    end
  end

`ifdef RAS_STATS_EN
  logic [15:0] r_hits;
  logic [15:0] r_misses;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hits   <= '0;
      r_misses <= '0;
    end else if (w_adv && pop) begin
      if (w_miss) begin
        if (r_misses != '1) r_misses <= r_misses + 16'd1;
      end else begin
        if (r_hits != '1) r_hits <= r_hits + 16'd1;
      end
    end
  end

  assign hit_count  = r_hits;
  assign miss_count = r_misses;
`endif

  assign pred_addr         = w_empty ? '0 : w_top;
  assign pred_valid        = !w_empty;
  assign mispredict        = r_mispredict;
  assign mispredict_target = r_mtarget;
  assign occupancy         = r_occ;

endmodule

// File: tb/tb_return_addr_stack.sv
// Directed self-checking bench for return_addr_stack (DEPTH = 8, AW = 32).
module tb_return_addr_stack;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        push;
  logic [31:0] push_addr;
  logic        pop;
  logic [31:0] jr_target;
  logic [31:0] pred_addr;
  logic        pred_valid;
  logic        mispredict;
  logic [31:0] mispredict_target;
  logic [3:0]  occupancy;
`ifdef RAS_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  int checks   = 0;
  int failures = 0;

  return_addr_stack #(.DEPTH(8), .AW(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .flush             (flush),
    .push              (push),
    .push_addr         (push_addr),
    .pop               (pop),
    .jr_target         (jr_target),
    .pred_addr         (pred_addr),
    .pred_valid        (pred_valid),
    .mispredict        (mispredict),
    .mispredict_target (mispredict_target),
    .occupancy         (occupancy)
`ifdef RAS_STATS_EN
    ,
    .hit_count         (hit_count),
    .miss_count        (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pu, input logic [31:0] pa, input logic po, input logic [31:0] jt);
    push = pu; push_addr = pa; pop = po; jr_target = jt;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    #12;
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_valid", 32'(pred_valid), 32'd0);
    chk("rst_pred", pred_addr, 32'h0);
    chk("rst_misp", 32'(mispredict), 32'd0);
    chk("rst_mtgt", mispredict_target, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // Basic push / matching pop
    drive(1'b1, 32'h100, 1'b0, 32'h0); step();
    chk("push1_pred", pred_addr, 32'h100);
    drive(1'b1, 32'h200, 1'b0, 32'h0); step();
    drive(1'b1, 32'h300, 1'b0, 32'h0); step();
    chk("push3_pred", pred_addr, 32'h300);
    chk("push3_occ", 32'(occupancy), 32'd3);
    chk("push3_valid", 32'(pred_valid), 32'd1);
    drive(1'b0, 32'h0, 1'b1, 32'h300); step();
    chk("pop_hit_misp", 32'(mispredict), 32'd0);
    chk("pop_hit_pred", pred_addr, 32'h200);
    chk("pop_hit_occ", 32'(occupancy), 32'd2);

    // Mismatched pop
    drive(1'b0, 32'h0, 1'b1, 32'h204); step();
    chk("pop_miss_misp", 32'(mispredict), 32'd1);
    chk("pop_miss_tgt", mispredict_target, 32'h204);
    chk("pop_miss_occ", 32'(occupancy), 32'd1);
    chk("pop_miss_pred", pred_addr, 32'h100);
    idle(); step();
    chk("misp_clear", 32'(mispredict), 32'd0);
    drive(1'b0, 32'h0, 1'b1, 32'h100); step();
    chk("drain_occ", 32'(occupancy), 32'd0);
    chk("drain_pred", pred_addr, 32'h0);
    chk("drain_misp", 32'(mispredict), 32'd0);

    // Overflow: nine pushes, oldest (0x10) lost
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 32'h10 + 32'(i), 1'b0, 32'h0); step();
    end
    chk("ovf_occ", 32'(occupancy), 32'd8);
    chk("ovf_pred", pred_addr, 32'h18);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 32'h0, 1'b1, 32'h18 - 32'(i)); step();
      chk($sformatf("ovf_pop%0d_misp", i), 32'(mispredict), 32'd0);
      chk($sformatf("ovf_pop%0d_occ", i), 32'(occupancy), 32'(7 - i));
    end
    drive(1'b0, 32'h0, 1'b1, 32'h10); step();
    chk("ovf_under_misp", 32'(mispredict), 32'd1);
    chk("ovf_under_tgt", mispredict_target, 32'h10);

    // Underflow from empty
    drive(1'b0, 32'h0, 1'b1, 32'h40); step();
    chk("under_misp", 32'(mispredict), 32'd1);
    chk("under_tgt", mispredict_target, 32'h40);
    chk("under_occ", 32'(occupancy), 32'd0);
    chk("under_valid", 32'(pred_valid), 32'd0);

    // Same-cycle push + pop replaces the top
    drive(1'b1, 32'h400, 1'b0, 32'h0); step();
    chk("under_clear", 32'(mispredict), 32'd0);
    drive(1'b1, 32'h500, 1'b0, 32'h0); step();
    drive(1'b1, 32'h600, 1'b1, 32'h500); step();
    chk("swap_misp", 32'(mispredict), 32'd0);
    chk("swap_pred", pred_addr, 32'h600);
    chk("swap_occ", 32'(occupancy), 32'd2);

    // Stall freezes everything including a pending mispredict
    drive(1'b0, 32'h0, 1'b1, 32'h999); step();
    chk("pre_stall_misp", 32'(mispredict), 32'd1);
    chk("pre_stall_occ", 32'(occupancy), 32'd1);
    stall = 1'b1;
    drive(1'b1, 32'h700, 1'b0, 32'h0); step();
    chk("stall_misp", 32'(mispredict), 32'd1);
    chk("stall_occ", 32'(occupancy), 32'd1);
    chk("stall_pred", pred_addr, 32'h400);
    chk("stall_tgt", mispredict_target, 32'h999);
    idle(); step();
    chk("post_stall_misp", 32'(mispredict), 32'd0);

    // Flush with a would-be-mispredicting pop
    flush = 1'b1;
    drive(1'b0, 32'h0, 1'b1, 32'h123); step();
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_misp", 32'(mispredict), 32'd0);
    chk("flush_valid", 32'(pred_valid), 32'd0);
    chk("flush_pred", pred_addr, 32'h0);
    idle();

    // Push + pop on empty: underflow check, then occupancy 1
    drive(1'b1, 32'h77, 1'b1, 32'h55); step();
    chk("swap_empty_misp", 32'(mispredict), 32'd1);
    chk("swap_empty_occ", 32'(occupancy), 32'd1);
    chk("swap_empty_pred", pred_addr, 32'h77);

    // Asynchronous reset mid-cycle
    drive(1'b1, 32'hAA, 1'b0, 32'h0); step();
    drive(1'b0, 32'h0, 1'b1, 32'h1); step();
    chk("pre_rst_misp", 32'(mispredict), 32'd1);
    chk("pre_rst_occ", 32'(occupancy), 32'd1);
    idle();
    #2 rst = 1'b0;
    #1;
    chk("async_rst_occ", 32'(occupancy), 32'd0);
    chk("async_rst_pred", pred_addr, 32'h0);
    chk("async_rst_valid", 32'(pred_valid), 32'd0);
    chk("async_rst_misp", 32'(mispredict), 32'd0);
    chk("async_rst_tgt", mispredict_target, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
